// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with a valid/ready handshake, flush-to-bubble, an optional
// 2-entry skid buffer (registered in_ready) and a saturating backpressure counter.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int DEST_W = 5,
    parameter int CTRL_W = 6,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a beat moves on a rising edge where valid and ready are both 1. A producer
    // holds its payload stable while valid=1 and ready=0; ready never depends on this
    // side's own valid, so there is no combinational loop through the handshake.
    logic              in_xfer;
    logic              out_xfer;

    // M drives the outputs; S catches one extra beat when the downstream stalls.
    logic              m_v;
    logic [DATA_W-1:0] m_data;
    logic [DEST_W-1:0] m_dest;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_v;
    logic [DATA_W-1:0] s_data;
    logic [DEST_W-1:0] s_dest;
    logic [CTRL_W-1:0] s_ctrl;
    logic              in_ready_q;

    logic              m_v_n;
    logic              s_v_n;
    logic              m_ld_in;
    logic              m_ld_s;
    logic              s_ld;

    assign in_ready  = (SKID != 0) ? in_ready_q : (!m_v | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = m_v & out_ready;

    assign out_valid = m_v;
    assign out_data  = m_data;
    assign out_dest  = m_dest;
    assign out_ctrl  = m_ctrl;

    always_comb begin
        m_v_n   = m_v;
        s_v_n   = s_v;
        m_ld_in = 1'b0;
        m_ld_s  = 1'b0;
        s_ld    = 1'b0;
        if (out_xfer) begin
            if ((SKID != 0) && s_v) begin
                // Oldest beat in S advances; a new arrival refills S behind it.
                m_ld_s = 1'b1;
                if (in_xfer) begin
                    s_ld = 1'b1;
                end else begin
                    s_v_n = 1'b0;
                end
            end else if (in_xfer) begin
                m_ld_in = 1'b1;
            end else begin
                m_v_n = 1'b0;
            end
        end else if (in_xfer) begin
            if (!m_v || (SKID == 0)) begin
                m_ld_in = 1'b1;
                m_v_n   = 1'b1;
            end else begin
                s_ld  = 1'b1;
                s_v_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_v        <= 1'b0;
            m_data     <= '0;
            m_dest     <= '0;
            m_ctrl     <= '0;
            s_v        <= 1'b0;
            s_data     <= '0;
            s_dest     <= '0;
            s_ctrl     <= '0;
            in_ready_q <= 1'b1;
            stall_cnt  <= '0;
        end else begin
            if (m_v && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                // Bubble: payload/dest left as-is, only valid and ctrl are killed.
                m_v        <= 1'b0;
                s_v        <= 1'b0;
                m_ctrl     <= '0;
                s_ctrl     <= '0;
                in_ready_q <= 1'b1;
            end else begin
                m_v        <= m_v_n;
                s_v        <= s_v_n;
                in_ready_q <= !s_v_n;
                if (m_ld_in) begin
                    m_data <= in_data;
                    m_dest <= in_dest;
                    m_ctrl <= in_ctrl;
                end else if (m_ld_s) begin
                    m_data <= s_data;
                    m_dest <= s_dest;
                    m_ctrl <= s_ctrl;
                end else if (!m_v_n) begin
                    m_ctrl <= '0;
                end
                if (s_ld) begin
                    s_data <= in_data;
                    s_dest <= in_dest;
                    s_ctrl <= in_ctrl;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (skid, no skid, 4-bit counter)
// share one set of inputs; each scenario resets first and checks the instance it targets.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [4:0]  in_dest;
    logic [5:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [4:0]  a_out_dest;
    logic [5:0]  a_out_ctrl;
    logic [15:0] a_stall_cnt;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [4:0]  b_out_dest;
    logic [5:0]  b_out_ctrl;
    logic [15:0] b_stall_cnt;

    logic        c_in_ready, c_out_valid;
    logic [63:0] c_out_data;
    logic [4:0]  c_out_dest;
    logic [5:0]  c_out_ctrl;
    logic [3:0]  c_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_reg #(.SKID(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_dest(a_out_dest), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.SKID(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_dest(b_out_dest), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_dest(c_out_dest), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [63:0] d, input logic [4:0] r, input logic [5:0] c);
        in_valid = v;
        in_data  = d;
        in_dest  = r;
        in_ctrl  = c;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
            out_ready = 1'($urandom_range(0, 1));
            flush = 1'b0;
            step();
        end
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        out_ready = 1'b0;
        step();
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_data !== 64'd0 || a_out_dest !== 5'd0 || a_out_ctrl !== 6'd0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h dest=%h ctrl=%h, required all 0",
                     a_out_valid, a_out_data, a_out_dest, a_out_ctrl);
        end
        n_vec++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: skid=%b noskid=%b, required 1/1", a_in_ready, b_in_ready);
        end
        n_vec++;
        if (a_stall_cnt !== 16'd0 || c_stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_stall_cnt: got %0d/%0d, required 0/0", a_stall_cnt, c_stall_cnt);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat(1'b1, 64'(i), 5'(i), 6'h3F);
            n_vec++;
            if (a_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_in_ready beat %0d: got %b, required 1", i, a_in_ready);
            end
            step();
            n_vec++;
            if (a_out_valid !== 1'b1 || a_out_data !== 64'(i) || a_out_dest !== 5'(i) || a_out_ctrl !== 6'h3F) begin
                n_err++;
                $display("FAIL stream_out beat %0d: valid=%b data=%0d dest=%0d ctrl=%h, required 1/%0d/%0d/3f",
                         i, a_out_valid, a_out_data, a_out_dest, a_out_ctrl, i, i);
            end
            n_vec++;
            if (b_out_valid !== 1'b1 || b_out_data !== 64'(i)) begin
                n_err++;
                $display("FAIL stream_noskid beat %0d: valid=%b data=%0d, required 1/%0d",
                         i, b_out_valid, b_out_data, i);
            end
        end
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        step();
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 6'd0 || a_stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL stream_drain: valid=%b ctrl=%h stall=%0d, required 0/00/0",
                     a_out_valid, a_out_ctrl, a_stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        beat(1'b1, 64'hA1, 5'd1, 6'h01);
        step();
        out_ready = 1'b0;
        beat(1'b1, 64'hB2, 5'd2, 6'h02);
        step();
        n_vec++;
        if (a_out_data !== 64'hA1 || a_in_ready !== 1'b0 || a_stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL bp_catch: data=%h in_ready=%b stall=%0d, required a1/0/1",
                     a_out_data, a_in_ready, a_stall_cnt);
        end
        beat(1'b1, 64'hC3, 5'd3, 6'h03);
        step();
        step();
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== 64'hA1 || a_in_ready !== 1'b0 || a_stall_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL bp_hold: valid=%b data=%h in_ready=%b stall=%0d, required 1/a1/0/3",
                     a_out_valid, a_out_data, a_in_ready, a_stall_cnt);
        end
        out_ready = 1'b1;
        step();
        n_vec++;
        if (a_out_data !== 64'hB2 || a_out_ctrl !== 6'h02 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_b: data=%h ctrl=%h in_ready=%b, required b2/02/1",
                     a_out_data, a_out_ctrl, a_in_ready);
        end
        step();
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== 64'hC3 || a_out_dest !== 5'd3) begin
            n_err++;
            $display("FAIL bp_release_c: valid=%b data=%h dest=%0d, required 1/c3/3",
                     a_out_valid, a_out_data, a_out_dest);
        end
        step();
        n_vec++;
        if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL bp_empty: valid=%b stall=%0d, required 0/3", a_out_valid, a_stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        beat(1'b1, 64'h11, 5'd1, 6'h15);
        step();
        out_ready = 1'b0;
        beat(1'b1, 64'h22, 5'd2, 6'h2A);
        step();
        flush = 1'b1;
        beat(1'b1, 64'hDD, 5'd13, 6'h3F);
        step();
        flush = 1'b0;
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 6'd0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full: valid=%b ctrl=%h in_ready=%b, required 0/00/1",
                     a_out_valid, a_out_ctrl, a_in_ready);
        end
        n_vec++;
        if (a_stall_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL flush_keeps_cnt: got %0d, required 2", a_stall_cnt);
        end
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        out_ready = 1'b1;
        step();
        beat(1'b1, 64'hEE, 5'd14, 6'h3F);
        step();
        flush = 1'b1;
        beat(1'b1, 64'hDD, 5'd13, 6'h3F);
        step();
        flush = 1'b0;
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 6'd0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_accepting: valid=%b ctrl=%h in_ready=%b, required 0/00/1",
                     a_out_valid, a_out_ctrl, a_in_ready);
        end
        step();
        n_vec++;
        if (a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_discard: valid=%b data=%h, required valid 0", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_noskid();
        do_reset();
        out_ready = 1'b1;
        beat(1'b1, 64'h51, 5'd5, 6'h05);
        step();
        out_ready = 1'b0;
        beat(1'b1, 64'h52, 5'd6, 6'h06);
        #1;
        n_vec++;
        if (b_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL noskid_comb_ready_low: got %b, required 0", b_in_ready);
        end
        step();
        n_vec++;
        if (b_out_valid !== 1'b1 || b_out_data !== 64'h51 || b_stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL noskid_hold: valid=%b data=%h stall=%0d, required 1/51/1",
                     b_out_valid, b_out_data, b_stall_cnt);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL noskid_comb_ready_high: got %b, required 1", b_in_ready);
        end
        step();
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        n_vec++;
        if (b_out_valid !== 1'b1 || b_out_data !== 64'h52 || b_out_ctrl !== 6'h06) begin
            n_err++;
            $display("FAIL noskid_refill: valid=%b data=%h ctrl=%h, required 1/52/06",
                     b_out_valid, b_out_data, b_out_ctrl);
        end
        step();
        n_vec++;
        if (b_out_valid !== 1'b0 || b_out_ctrl !== 6'd0) begin
            n_err++;
            $display("FAIL noskid_empty: valid=%b ctrl=%h, required 0/00", b_out_valid, b_out_ctrl);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        beat(1'b1, 64'h77, 5'd7, 6'h07);
        step();
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (c_stall_cnt !== 4'd15 || a_stall_cnt !== 16'd20) begin
            n_err++;
            $display("FAIL sat_reach: cnt4=%0d cnt16=%0d, required 15/20", c_stall_cnt, a_stall_cnt);
        end
        step();
        n_vec++;
        if (c_stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_hold: got %0d, required 15", c_stall_cnt);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_vec++;
        if (c_stall_cnt !== 4'd15 || a_stall_cnt !== 16'd22) begin
            n_err++;
            $display("FAIL sat_flush: cnt4=%0d cnt16=%0d, required 15/22", c_stall_cnt, a_stall_cnt);
        end
        do_reset();
        n_vec++;
        if (c_stall_cnt !== 4'd0 || a_stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL sat_reset: cnt4=%0d cnt16=%0d, required 0/0", c_stall_cnt, a_stall_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        beat(1'b0, 64'd0, 5'd0, 6'd0);
        step();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipeline boundaries (ID/EX, EX/MEM, MEM/WB). It carries a payload, destination register and control field from one stage to the next. Unlike the plain boundary register, it adds:
- a valid/ready handshake,
- synchronous flush that inserts a bubble,
- an optional 2-entry skid buffer so that `in_ready` is driven from a register,
- a saturating backpressure counter for performance debug.

## Interface
Parameters:
- `DATA_W`, 64, payload width (e.g. ALU result ++ store data)
- `DEST_W`, 5, destination register index width
- `CTRL_W`, 6, control-signal field width (M ++ WB bits); zeroed on bubbles
- `SKID`, 1, 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_data`  in  DATA_W  payload
- `in_dest`  in  DEST_W  destination register
- `in_ctrl`  in  CTRL_W  control signals
- `flush`  in  1  kill all held beats and the beat presented this cycle
- `out_valid`  out  1  downstream beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DATA_W  payload
- `out_dest`  out  DEST_W  destination
- `out_ctrl`  out  CTRL_W  control; 0 whenever `out_valid`=0
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0

## Operation
- A transfer occurs when valid and ready are both 1 at a rising edge: `in_xfer` = `in_valid`&`in_ready`, `out_xfer` = `out_valid`&`out_ready`.
- Storage: main register M, which drives all outputs directly. When SKID=1 there is also a skid register S. Beats leave in the order they arrived. Beats are never duplicated or dropped except by flush.
- SKID=0:
  - `in_ready` = !M.v | `out_ready`.
  - On `in_xfer`, M loads the input. On `out_xfer` without `in_xfer`, M.v goes to 0.
- SKID=1:
  - `in_ready` = !S.v, registered.
  - `in_xfer` while M is empty, or while M is draining (`out_xfer`), writes M.
  - `in_xfer` while M is full and `out_ready`=0 writes S.
  - `out_xfer` while S.v=1 moves S into M. If there is a simultaneous `in_xfer`, the new beat goes to S.
  - Occupancy is 0..2. `in_ready` is 0 exactly when occupancy is 2.
- Flush, sampled at the rising edge:
  - M.v and S.v go to 0, and the ctrl registers go to 0.
  - A beat accepted in the same cycle (`in_xfer`) is discarded.
  - `out_data` and `out_dest` hold their previous values (don't-care).
  - The occupancy counter is not used, so no other state changes.
  - Next cycle: `in_ready`=1 and `out_valid`=0.
- `out_ctrl` register: it is written with the beat's ctrl when M loads. It is written with 0 in every cycle in which M ends the cycle empty.
- `stall_cnt`:
  - Increments by 1 each cycle with `out_valid` & !`out_ready`.
  - Saturates at 2^CNT_W−1.
  - Unaffected by flush; cleared only by reset.
- Reset (`rst`=0 at an edge) has priority over flush and handshakes. It sets:
  - M.v, S.v = 0
  - `out_valid` = 0
  - `out_data`, `out_dest`, `out_ctrl` = 0
  - `stall_cnt` = 0
  - `in_ready` = 1 (SKID=1 registered value; SKID=0 follows from !M.v)

## Timing
- Latency: 1 cycle from `in_xfer` to `out_valid` when empty. A beat that was in S reaches the outputs 1 cycle after the `out_xfer` of the beat ahead of it.
- Throughput: 1 beat/cycle with `out_ready` held at 1, for both SKID values.
- SKID=1, when `out_ready` falls with M full and `in_valid`=1:
  - The beat in that cycle is caught in S.
  - `in_ready` is 0 from the next cycle.
  - `in_ready` returns to 1 the cycle after the first subsequent `out_xfer`.
- SKID=0: `in_ready` changes in the same cycle as `out_ready` (combinational path).
- The upstream side must hold `in_*` stable while `in_valid`=1 & `in_ready`=0. The block guarantees `out_*` are stable while `out_valid`=1 & `out_ready`=0.
- All outputs except SKID=0 `in_ready` are registered.

## Test plan
- Reset: drive random inputs, then `rst`=0 for 2 cycles. Required: all outputs 0, `in_ready`=1, and `stall_cnt`=0 the cycle after release.
- Streaming, SKID=1: send beats A..H (`data` = 1..8, `dest` = 1..8, `ctrl` = 6'h3F) with `out_ready`=1. Required: each beat appears exactly 1 cycle after acceptance, back to back, in order.
- Backpressure, SKID=1: stream A,B,C and drop `out_ready` on the cycle A is at the output.
  - Required: A is held and B goes to S; `in_ready`=0 the next cycle; C is held upstream.
  - Raising `out_ready` yields A,B,C in order with no loss; `stall_cnt` equals the number of stalled cycles.
- Flush: M and S full, with `flush`=1 while D is presented with `in_valid`=1. Required next cycle: `out_valid`=0, `out_ctrl`=0, `in_ready`=1; D never appears at the output.
- SKID=0 variant: `out_ready`=0 with M full. Required: `in_ready`=0 in the same cycle. Raising `out_ready` and `in_valid` together gives the drain and refill in one edge.
- Saturation, CNT_W=4: hold `out_valid`=1 & `out_ready`=0 for 20 cycles. Required: `stall_cnt` = 15 and it stays there. Flush does not clear it; reset does.
